// File: rtl/alu_pipe.sv
// Pipelined 8-op ALU with valid/ready handshake on both sides and an iterative restoring divider.
// Results are 2*WIDTH wide and carry zero / divide-by-zero status flags.
module alu_pipe #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [2:0]           opcode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 zero_flag,
   output logic                 dz_flag
);

   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_NAND = 3'b110;
   localparam logic [2:0] OP_NOR  = 3'b111;

   typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              zero_q, zero_d;
   logic              dz_q, dz_d;
   logic [WIDTH-1:0]  quot_q, quot_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  divisor_q, divisor_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [RW-1:0]     opa_c, opb_c, alu_res_c;
   logic              alu_dz_c, accept_c, start_div_c;
   logic [WIDTH:0]    div_shift_c;
   logic              div_ge_c;
   logic [WIDTH-1:0]  quot_next_c, rem_next_c;

   assign in_ready  = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept_c  = in_valid && in_ready;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign zero_flag = zero_q;
   assign dz_flag   = dz_q;

   // Single-cycle datapath; div here only covers the divide-by-zero case.
   always_comb begin
      opa_c     = RW'(in1);
      opb_c     = RW'(in2);
      alu_res_c = '0;
      alu_dz_c  = 1'b0;
      case (opcode)
         OP_ADD:  alu_res_c = opa_c + opb_c;
         OP_SUB:  alu_res_c = opa_c - opb_c;
         OP_MUL:  alu_res_c = opa_c * opb_c;
         OP_DIV:  begin
            alu_res_c = '1;
            alu_dz_c  = 1'b1;
         end
         OP_OR:   alu_res_c = opa_c | opb_c;
         OP_AND:  alu_res_c = opa_c & opb_c;
         OP_NAND: alu_res_c = ~(opa_c & opb_c);
         OP_NOR:  alu_res_c = ~(opa_c | opb_c);
         default: alu_res_c = '0;
      endcase
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      div_shift_c = {rem_q, quot_q[WIDTH-1]};
      div_ge_c    = div_shift_c >= {1'b0, divisor_q};
      quot_next_c = {quot_q[WIDTH-2:0], div_ge_c};
      rem_next_c  = div_ge_c ? (div_shift_c[WIDTH-1:0] - divisor_q) : div_shift_c[WIDTH-1:0];
   end

   assign start_div_c = accept_c && (opcode == OP_DIV) && (in2 != '0);

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      zero_d      = zero_q;
      dz_d        = dz_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      divisor_d   = divisor_q;
      cnt_d       = cnt_q;

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_div_c) begin
               state_d   = DIV;
               quot_d    = in1;
               rem_d     = '0;
               divisor_d = in2;
               cnt_d     = '0;
            end else if (accept_c) begin
               out_d       = alu_res_c;
               out_valid_d = 1'b1;
               zero_d      = (alu_res_c == '0);
               dz_d        = alu_dz_c;
            end
         end
         DIV: begin
            quot_d = quot_next_c;
            rem_d  = rem_next_c;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = IDLE;
               cnt_d       = '0;
               out_d       = RW'(quot_next_c);
               out_valid_d = 1'b1;
               zero_d      = (quot_next_c == '0);
               dz_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         dz_q        <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         dz_q        <= dz_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         divisor_q   <= divisor_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=4 and WIDTH=8; inputs driven and outputs sampled on the falling edge.
module tb_alu_pipe;

   logic       clk;
   logic       rst, iv, ir, ov, ordy, zf, dzf;
   logic [3:0] a, b;
   logic [2:0] op;
   logic [7:0] res;

   logic        rst8, iv8, ir8, ov8, ordy8, zf8, dz8;
   logic [7:0]  a8, b8;
   logic [2:0]  op8;
   logic [15:0] res8;

   int n_cmp = 0;
   int n_err = 0;

   logic [2:0] bb_op  [7] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd4, 3'd5};
   logic [3:0] bb_a   [7] = '{4'h9, 4'h3, 4'hF, 4'hF, 4'h0, 4'h5, 4'h5};
   logic [3:0] bb_b   [7] = '{4'h7, 4'h5, 4'hF, 4'hF, 4'h0, 4'hA, 4'hA};
   logic [7:0] bb_exp [7] = '{8'h10, 8'hFE, 8'hE1, 8'hF0, 8'hFF, 8'h0F, 8'h00};
   logic       bb_z   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic [3:0] dv_a   [3] = '{4'd13, 4'd15, 4'd2};
   logic [3:0] dv_b   [3] = '{4'd4, 4'd1, 4'd7};
   logic [7:0] dv_exp [3] = '{8'h03, 8'h0F, 8'h00};
   logic       dv_z   [3] = '{1'b0, 1'b0, 1'b1};

   alu_pipe #(.WIDTH(4)) dut4 (
      .clock(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .in1(a), .in2(b), .opcode(op),
      .out_valid(ov), .out_ready(ordy), .out(res), .zero_flag(zf), .dz_flag(dzf)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8), .opcode(op8),
      .out_valid(ov8), .out_ready(ordy8), .out(res8), .zero_flag(zf8), .dz_flag(dz8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; op = '0;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({ov, res, zf, dzf, ir} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", {ov, res, zf, dzf, ir}, 12'h000);
         end
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (ir !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b expected 1", ir);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_cmp++;
            if ({ov, res, zf, dzf} !== {1'b1, bb_exp[i-1], bb_z[i-1], 1'b0}) begin
               n_err++;
               $display("FAIL b2b_%0d: got %h expected %h", i - 1, {ov, res, zf, dzf},
                        {1'b1, bb_exp[i-1], bb_z[i-1], 1'b0});
            end
         end
         if (i < 7) begin
            iv = 1'b1; op = bb_op[i]; a = bb_a[i]; b = bb_b[i];
         end else begin
            iv = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (ov !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_drain: got %b expected 0", ov);
      end
   endtask

   task automatic test_div();
      for (int v = 0; v < 3; v++) begin
         @(negedge clk);
         iv = 1'b1; op = 3'd3; a = dv_a[v]; b = dv_b[v];
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) iv = 1'b0;
            n_cmp++;
            if ({ir, ov} !== 2'b00) begin
               n_err++;
               $display("FAIL div_busy_%0d_%0d: got %b expected 00", v, k, {ir, ov});
            end
         end
         @(negedge clk);
         n_cmp++;
         if ({ov, res, zf, dzf, ir} !== {1'b1, dv_exp[v], dv_z[v], 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL div_result_%0d: got %h expected %h", v, {ov, res, zf, dzf, ir},
                     {1'b1, dv_exp[v], dv_z[v], 1'b0, 1'b1});
         end
      end
   endtask

   task automatic test_div_zero();
      @(negedge clk);
      iv = 1'b1; op = 3'd3; a = 4'd9; b = 4'd0;
      @(negedge clk);
      n_cmp++;
      if ({ov, res, zf, dzf} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL div_zero: got %h expected %h", {ov, res, zf, dzf}, {1'b1, 8'hFF, 1'b0, 1'b1});
      end
      op = 3'd0; a = 4'd1; b = 4'd1;
      @(negedge clk);
      iv = 1'b0;
      n_cmp++;
      if ({ov, res, zf, dzf} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL div_zero_next: got %h expected %h", {ov, res, zf, dzf}, {1'b1, 8'h02, 1'b0, 1'b0});
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      iv = 1'b1; op = 3'd2; a = 4'd6; b = 4'd7;
      @(negedge clk);
      ordy = 1'b0; op = 3'd0; a = 4'd1; b = 4'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if ({ov, res, ir} !== {1'b1, 8'h2A, 1'b0}) begin
            n_err++;
            $display("FAIL bp_hold_%0d: got %h expected %h", k, {ov, res, ir}, {1'b1, 8'h2A, 1'b0});
         end
         @(negedge clk);
      end
      ordy = 1'b1;
      #1;
      n_cmp++;
      if (ir !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release_ready: got %b expected 1", ir);
      end
      @(negedge clk);
      iv = 1'b0;
      n_cmp++;
      if ({ov, res, zf} !== {1'b1, 8'h03, 1'b0}) begin
         n_err++;
         $display("FAIL bp_no_bubble: got %h expected %h", {ov, res, zf}, {1'b1, 8'h03, 1'b0});
      end
   endtask

   task automatic test_reset_mid_div();
      @(negedge clk);
      iv = 1'b1; op = 3'd3; a = 4'd15; b = 4'd3;
      @(negedge clk);
      iv = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ov, res, ir} !== 10'h000) begin
         n_err++;
         $display("FAIL abort_reset: got %h expected %h", {ov, res, ir}, 10'h000);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({ov, ir} !== 2'b01 || res === 8'h05) begin
            n_err++;
            $display("FAIL abort_quiet_%0d: got %h expected %h", k, {ov, ir, res}, 10'h100);
         end
      end
      iv = 1'b1; op = 3'd0; a = 4'd2; b = 4'd2;
      @(negedge clk);
      iv = 1'b0;
      n_cmp++;
      if ({ov, res, zf, dzf} !== {1'b1, 8'h04, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL abort_next_add: got %h expected %h", {ov, res, zf, dzf}, {1'b1, 8'h04, 1'b0, 1'b0});
      end
   endtask

   task automatic test_width8();
      @(negedge clk);
      n_cmp++;
      if ({ov8, res8, ir8} !== 18'h0) begin
         n_err++;
         $display("FAIL w8_reset: got %h expected %h", {ov8, res8, ir8}, 18'h0);
      end
      rst8 = 1'b0;
      iv8 = 1'b1; op8 = 3'd2; a8 = 8'd255; b8 = 8'd255;
      @(negedge clk);
      n_cmp++;
      if ({ov8, res8, zf8, dz8} !== {1'b1, 16'hFE01, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL w8_mul: got %h expected %h", {ov8, res8, zf8, dz8}, {1'b1, 16'hFE01, 1'b0, 1'b0});
      end
      op8 = 3'd3; a8 = 8'd200; b8 = 8'd7;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) iv8 = 1'b0;
         n_cmp++;
         if ({ir8, ov8} !== 2'b00) begin
            n_err++;
            $display("FAIL w8_div_busy_%0d: got %b expected 00", k, {ir8, ov8});
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({ov8, res8, zf8, dz8} !== {1'b1, 16'h001C, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL w8_div: got %h expected %h", {ov8, res8, zf8, dz8}, {1'b1, 16'h001C, 1'b0, 1'b0});
      end
   endtask

   initial begin
      rst8 = 1'b1; iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
      test_reset();
      test_back_to_back();
      test_div();
      test_div_zero();
      test_backpressure();
      test_reset_mid_div();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit registered ALU: same 8-opcode set, with generic operand WIDTH and a full-width 2*WIDTH result.
- Adds a valid/ready handshake on input and output, an iterative multi-cycle divider, and status flags (zero, divide-by-zero).
- Sits between an operand source (sequencer or FIFO) and a result sink that may apply backpressure.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..32); result width is 2*WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in1  input  WIDTH  operand A, unsigned.
- in2  input  WIDTH  operand B, unsigned.
- opcode  input  3  000 add, 001 sub, 010 mul, 011 div, 100 or, 101 and, 110 nand, 111 nor.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result this cycle.
- out  output  2*WIDTH  result.
- zero_flag  output  1  out == 0; qualified by out_valid.
- dz_flag  output  1  result came from a divide by zero; qualified by out_valid.

Behaviour:
- Reset: one clock is a single clock; reset is synchronous and active-high. While reset is sampled high at a rising edge, the block forces:
  - state = IDLE
  - out = 0, out_valid = 0, zero_flag = 0, dz_flag = 0
  - divider registers = 0
  - in_ready is low during reset cycles.
- Reset mid-divide aborts the operation; no result is produced.
- Handshake:
  - Input accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_ready = (state != DIV) && (!out_valid || out_ready).
  - out, zero_flag and dz_flag stay stable while out_valid && !out_ready.
  - out_valid drops after a transfer unless a new result loads in the same edge.
- States:
  - IDLE: accept beats.
  - DIV: iterating; in_ready = 0.
  - The output register is independent of state.
- Latency, single-cycle ops (all except div, and div with in2 == 0): beat accepted at edge t gives the result registered at edge t, visible with out_valid in the following cycle. Sustained throughput is 1 beat/cycle when out_ready = 1.
- Latency, divide with in2 != 0:
  - Accept at edge t latches the operands and enters DIV.
  - Restoring division, one quotient bit per cycle, for WIDTH iterations.
  - The last iteration loads out and returns to IDLE at edge t+WIDTH; out_valid is high in the cycle after.
  - in_ready is low for WIDTH cycles.
  - The divider never starts while an unaccepted result is held, because in_ready gates acceptance.
- Arithmetic: operands are zero-extended to 2*WIDTH before the op; the result is truncated to 2*WIDTH.
  - add: in1+in2 (carry kept).
  - sub: in1-in2, 2*WIDTH two's complement (3-5 gives all-ones upper bits).
  - mul: full unsigned product.
  - div: quotient zero-extended; remainder discarded. in2 == 0 gives out = all ones (2*WIDTH) and dz_flag = 1, single-cycle.
  - or / and: zero-extended, so upper WIDTH bits are 0.
  - nand / nor: bitwise inverse of the 2*WIDTH zero-extended operation, so upper WIDTH bits are 1.
- zero_flag = (out == 0), registered with out. dz_flag is 0 for every other op.
- Simultaneous output transfer and input accept in the same cycle: the new single-cycle result replaces the old one, out_valid stays 1, and no bubble is inserted.
- X or unknown opcode cannot occur (3-bit, fully decoded).

Test Plan:
- WIDTH=4, reset held 2 cycles then released. Expected: out=0x00, out_valid=0 during reset; in_ready=1 on the first cycle after reset.
- Back-to-back beats with out_ready=1:
  - add 9,7 gives 0x10
  - sub 3,5 gives 0xFE
  - mul 15,15 gives 0xE1
  - nand F,F gives 0xF0
  - nor 0,0 gives 0xFF
  - or 5,A gives 0x0F
  - Each result appears one cycle after its accept, one per cycle, with zero_flag=0.
  - and 5,A gives 0x00 with zero_flag=1.
- div 13,4: in_ready low for 4 cycles, out=0x03 with out_valid 5 cycles after the accept, dz_flag=0. Also div 15,1 gives 0x0F and div 2,7 gives 0x00 with zero_flag=1.
- div 9,0: out=0xFF, dz_flag=1 one cycle after the accept; a following add 1,1 gives 0x02 with dz_flag=0.
- Backpressure: out_ready=0 for 3 cycles after mul 6,7. Expected: out holds 0x2A, in_ready=0 while held; on release, the transfer and a new accept happen in the same cycle with no bubble.
- Reset asserted at the 2nd divide iteration of div 15,3: out_valid stays 0 and no 0x05 result ever appears; the next add 2,2 gives 0x04. Repeat the directed vectors at WIDTH=8: mul 255,255 gives 0xFE01; div 200,7 gives 0x001C after 8 cycles.
